// File: rtl/button_event_queue.sv
// Converts debounced button levels into PRESS/RELEASE/REPEAT events. The events are queued
// in a show-ahead FIFO and drained over a valid/ready interface.
module button_event_queue #(
    parameter int unsigned NUM_BUTTONS   = 4,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned FIFO_DEPTH    = 4,
    localparam int unsigned IdxW         = $clog2(NUM_BUTTONS),
    localparam int unsigned CodeW        = 2 + IdxW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] btn,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [CodeW-1:0]       evt_code,
    output logic [NUM_BUTTONS-1:0] held,
    output logic                   overflow,
    input  logic                   overflow_clr
);

    localparam int unsigned MaxCyc = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);

    localparam logic [1:0] KindNone    = 2'b00;
    localparam logic [1:0] KindPress   = 2'b01;
    localparam logic [1:0] KindRelease = 2'b10;
    localparam logic [1:0] KindRepeat  = 2'b11;

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} hold_state_e;

    logic [NUM_BUTTONS-1:0] btn_q, btn_qq, rise, fall, fire;
    hold_state_e            st_q   [NUM_BUTTONS];
    hold_state_e            st_d   [NUM_BUTTONS];
    logic [CntW-1:0]        cnt_q  [NUM_BUTTONS];
    logic [CntW-1:0]        cnt_d  [NUM_BUTTONS];
    logic [1:0]             slot_q [NUM_BUTTONS];
    logic [1:0]             slot_d [NUM_BUTTONS];
    logic [1:0]             new_kind [NUM_BUTTONS];
    logic [CodeW-1:0]       mem_q  [FIFO_DEPTH];
    logic [PtrW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d, ovf_set;
    logic                   sel_found, push, pop, full, empty;
    logic [IdxW-1:0]        sel_idx;
    logic [CodeW-1:0]       push_code;

    assign rise = btn_q & ~btn_qq;
    assign fall = ~btn_q & btn_qq;

    always_comb begin
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            fire[i]  = 1'b0;
            if (fall[i]) begin
                st_d[i]  = StIdle;
                cnt_d[i] = '0;
            end else begin
                case (st_q[i])
                    StIdle: begin
                        if (rise[i]) begin
                            st_d[i]  = StDelay;
                            cnt_d[i] = '0;
                        end
                    end
                    // Fire on the last count so the REPEAT lands exactly HOLD_CYCLES after PRESS
                    StDelay: begin
                        if (cnt_q[i] == CntW'(HOLD_CYCLES - 1)) begin
                            st_d[i]  = StRepeat;
                            cnt_d[i] = '0;
                            fire[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CntW'(1);
                        end
                    end
                    StRepeat: begin
                        if (cnt_q[i] == CntW'(REPEAT_CYCLES - 1)) begin
                            cnt_d[i] = '0;
                            fire[i]  = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CntW'(1);
                        end
                    end
                    default: st_d[i] = StIdle;
                endcase
            end
        end
    end

    // Lowest index wins; loop runs downward so the last hit is the smallest index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (slot_q[i] != KindNone) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop       = !empty && evt_ready;
    assign push      = sel_found && (!full || pop);
    assign push_code = {slot_q[sel_idx], sel_idx};
    assign wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_comb begin
        ovf_set = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            slot_d[i]   = slot_q[i];
            new_kind[i] = rise[i] ? KindPress :
                          fall[i] ? KindRelease :
                          fire[i] ? KindRepeat : KindNone;
            if (push && sel_idx == IdxW'(i)) begin
                slot_d[i] = KindNone;
            end
            if (new_kind[i] != KindNone) begin
                if (slot_d[i] == KindNone) begin
                    slot_d[i] = new_kind[i];
                end else if (new_kind[i] != KindRepeat) begin
                    ovf_set = 1'b1;
                end
            end
        end
        overflow_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q      <= '0;
            btn_qq     <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                st_q[i]   <= StIdle;
                cnt_q[i]  <= '0;
                slot_q[i] <= KindNone;
            end
        end else begin
            btn_q      <= btn;
            btn_qq     <= btn_q;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                st_q[i]   <= st_d[i];
                cnt_q[i]  <= cnt_d[i];
                slot_q[i] <= slot_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= push_code;
        end
    end

    assign evt_valid = !empty;
    assign evt_code  = mem_q[rd_ptr_q[PtrW-1:0]];
    assign held      = btn_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Randomized and directed stimulus for button_event_queue, compared every cycle against
// an event-level reference model (elapsed-hold arithmetic, pending slots, queue).
module tb_button_event_queue;

    localparam int NB = 4;
    localparam int H  = 8;
    localparam int R  = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic          evt_ready = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          evt_valid;
    logic [3:0]    evt_code;
    logic [NB-1:0] held;
    logic          overflow;

    button_event_queue #(
        .NUM_BUTTONS  (NB),
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_code    (evt_code),
        .held        (held),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [NB-1:0] m_bq, m_bqq;
    int            m_slot [NB];   // 0 empty, else kind
    int            m_age  [NB];   // cycles since PRESS was set, -1 when not held
    logic [3:0]    m_q[$];
    logic          m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_bq  = '0;
        m_bqq = '0;
        m_ovf = 1'b0;
        m_q.delete();
        for (int i = 0; i < NB; i++) begin
            m_slot[i] = 0;
            m_age[i]  = -1;
        end
    endtask

    task automatic model_step(input logic [NB-1:0] b, input logic r, input logic c);
        int   sel = -1;
        int   kind;
        logic pop, can_push, rise, fall, rep, lost;
        lost = 1'b0;
        for (int i = NB - 1; i >= 0; i--) if (m_slot[i] != 0) sel = i;
        pop      = (m_q.size() > 0) && r;
        can_push = (m_q.size() < D) || pop;
        if (pop) void'(m_q.pop_front());
        if (sel >= 0 && can_push) begin
            m_q.push_back(4'((m_slot[sel] << 2) | sel));
            m_slot[sel] = 0;
        end
        for (int i = 0; i < NB; i++) begin
            rise = m_bq[i] && !m_bqq[i];
            fall = !m_bq[i] && m_bqq[i];
            rep  = (m_age[i] >= 0) && !fall &&
                   ((m_age[i] + 1 == H) || (m_age[i] + 1 > H && (m_age[i] + 1 - H) % R == 0));
            kind = rise ? 1 : fall ? 2 : rep ? 3 : 0;
            if (kind != 0) begin
                if (m_slot[i] == 0) m_slot[i] = kind;
                else if (kind != 3) lost = 1'b1;
            end
            if (rise) m_age[i] = 0;
            else if (fall) m_age[i] = -1;
            else if (m_age[i] >= 0) m_age[i]++;
        end
        if (lost) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_bqq = m_bq;
        m_bq  = b;
    endtask

    task automatic compare_all();
        check("valid", 32'(evt_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("code", 32'(evt_code), 32'(m_q[0]));
        check("held", 32'(held), 32'(m_bq));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Entered and left at a negedge.
    task automatic cyc(input logic [NB-1:0] b, input logic r, input logic c);
        btn          = b;
        evt_ready    = r;
        overflow_clr = c;
        @(posedge clk);
        model_step(b, r, c);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic run(input logic [NB-1:0] b, input logic r, input int n);
        for (int k = 0; k < n; k++) cyc(b, r, 1'b0);
    endtask

    task automatic do_reset(input logic [NB-1:0] b);
        btn   = b;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_code", 32'(evt_code), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NB-1:0] rb;
        logic          rr;
        model_reset();
        @(negedge clk);
        do_reset(4'b0000);
        // Button held through reset release: PRESS index 2 visible after 3 edges
        do_reset(4'b0100);
        run(4'b0100, 1'b1, 3);
        check("rst_press", {27'd0, evt_valid, evt_code}, 32'b1_0110);
        run(4'b0000, 1'b1, 5);
        // Short press/release
        run(4'b0010, 1'b1, 3);
        run(4'b0000, 1'b1, 6);
        // Auto-repeat
        run(4'b0001, 1'b1, 30);
        run(4'b0000, 1'b1, 8);
        // Simultaneous rises
        run(4'b1011, 1'b1, 5);
        run(4'b0000, 1'b1, 8);
        // Backpressure with lost events, then drain and clear
        for (int i = 0; i < NB; i++) begin
            run(4'(1 << i), 1'b0, 2);
            run(4'b0000, 1'b0, 2);
        end
        check("bp_overflow", 32'(overflow), 32'd1);
        check("bp_head", {27'd0, evt_valid, evt_code}, 32'b1_0100);
        run(4'b0000, 1'b1, 20);
        cyc(4'b0000, 1'b1, 1'b1);
        check("clr_overflow", 32'(overflow), 32'd0);
        // Full FIFO with repeats pending, then simultaneous pop/push
        run(4'b1111, 1'b0, 12);
        run(4'b1111, 1'b1, 6);
        run(4'b0000, 1'b1, 15);
        // Randomized traffic with one mid-run reset
        rb = '0;
        rr = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                do_reset(4'($urandom_range(0, 15)));
                rb = btn;
            end
            for (int i = 0; i < NB; i++) if ($urandom_range(0, 11) == 0) rb[i] = ~rb[i];
            if (n % 200 < 100) rr = ($urandom_range(0, 3) != 0);
            else rr = ($urandom_range(0, 7) == 0);
            cyc(rb, rr, ($urandom_range(0, 15) == 0));
        end
        run(4'b0000, 1'b1, 20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
